// File: rtl/fir_mc.sv
// Multi-channel time-multiplexed FIR filter: C delay lines share one coefficient bank
// and one multiply-accumulate unit that runs N cycles per accepted sample.
module fir_mc #(
  parameter int N = 16,
  parameter int M = 24,
  parameter int C = 4,
  parameter int K = 16,
  localparam int CW = (C > 1) ? $clog2(C) : 1,
  localparam int AW = $clog2(N)
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic signed [M-1:0]  in,
  input  logic [CW-1:0]        in_ch,
  input  logic                 input_ready,
  output logic                 busy,
  input  logic                 clear,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [K-1:0]  coef_data,
  output logic signed [M-1:0]  out,
  output logic [CW-1:0]        out_ch,
  output logic                 output_ready
);

  localparam int PW   = M + K;
  localparam int ACCW = M + K + $clog2(N);
  localparam int RW   = ACCW - (K - 1);

  localparam logic signed [ACCW-1:0] RND  = {{(ACCW-1){1'b0}}, 1'b1} << (K - 2);
  localparam logic signed [RW-1:0]   SMAX = {{(RW-M+1){1'b0}}, {(M-1){1'b1}}};
  localparam logic signed [RW-1:0]   SMIN = {{(RW-M+1){1'b1}}, {(M-1){1'b0}}};

  typedef enum logic [1:0] {WAITING, LOADING, PROCESSING, SAVING} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic signed [M-1:0]     r_hold;
  logic [CW-1:0]           r_ch;
  logic [AW-1:0]           r_addr;
  logic signed [ACCW-1:0]  r_acc;
  logic signed [M-1:0]     r_lines [C][N];
  logic signed [K-1:0]     r_coef  [N];
  logic                    w_accept;
  logic [CW-1:0]           w_ch_mod;
  logic signed [M-1:0]     w_tap;
  logic signed [PW-1:0]    w_prod;

  function automatic logic signed [RW-1:0] f_round(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] t;
    t = a + RND;
    return RW'(t >>> (K - 1));
  endfunction

  function automatic logic signed [M-1:0] f_sat(input logic signed [RW-1:0] v);
    logic signed [RW-1:0] c;
    if (v > SMAX)      c = SMAX;
    else if (v < SMIN) c = SMIN;
    else               c = v;
    return c[M-1:0];
  endfunction

  assign busy     = (r_state != WAITING);
  assign w_accept = (r_state == WAITING) && input_ready;
  assign w_ch_mod = CW'(32'(in_ch) % C);
  assign w_tap    = r_lines[r_ch][r_addr];
  assign w_prod   = PW'(w_tap) * PW'(r_coef[r_addr]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAITING:    if (input_ready) w_next = LOADING;
      LOADING:    w_next = PROCESSING;
      PROCESSING: if (r_addr == AW'(N - 1)) w_next = SAVING;
      SAVING:     w_next = WAITING;
      default:    w_next = WAITING;
    endcase
  end

  // Control and MAC pipeline: capture, accumulate over N taps, then round/saturate.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state      <= WAITING;
      r_hold       <= '0;
      r_ch         <= '0;
      r_addr       <= '0;
      r_acc        <= '0;
      out          <= '0;
      out_ch       <= '0;
      output_ready <= 1'b0;
    end else begin
      r_state      <= w_next;
      output_ready <= 1'b0;
      if (w_accept) begin
        r_hold <= in;
        r_ch   <= w_ch_mod;
      end
      if (r_state == LOADING) begin
        r_acc  <= '0;
        r_addr <= '0;
      end
      if (r_state == PROCESSING) begin
        r_acc  <= r_acc + ACCW'(w_prod);
        r_addr <= r_addr + AW'(1);
      end
      if (r_state == SAVING) begin
        out          <= f_sat(f_round(r_acc));
        out_ch       <= r_ch;
        output_ready <= 1'b1;
      end
    end
  end

  // Delay lines: clear and shift never coincide since they live in different states.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < C; c++)
        for (int i = 0; i < N; i++)
          r_lines[c][i] <= '0;
    end else if ((r_state == WAITING) && clear) begin
      for (int c = 0; c < C; c++)
        for (int i = 0; i < N; i++)
          r_lines[c][i] <= '0;
    end else if (r_state == LOADING) begin
      r_lines[r_ch][0] <= r_hold;
      for (int i = 1; i < N; i++)
        r_lines[r_ch][i] <= r_lines[r_ch][i-1];
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        r_coef[i] <= '0;
    end else if (!busy && coef_we) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_mc.sv
// Scoreboard bench for fir_mc: a behavioural model queues expected outputs at accept time.
module tb_fir_mc;
  localparam int N  = 16;
  localparam int M  = 24;
  localparam int C  = 4;
  localparam int K  = 16;
  localparam int CW = 2;
  localparam int AW = 4;

  logic                ck;
  logic                rst;
  logic signed [M-1:0] in;
  logic [CW-1:0]       in_ch;
  logic                input_ready;
  logic                busy;
  logic                clear;
  logic                coef_we;
  logic [AW-1:0]       coef_addr;
  logic signed [K-1:0] coef_data;
  logic signed [M-1:0] out;
  logic [CW-1:0]       out_ch;
  logic                output_ready;

  int checks = 0;
  int errors = 0;

  logic signed [M-1:0] q_d[$];
  logic [CW-1:0]       q_c[$];
  longint              m_line [C][N];
  longint              m_coef [N];

  fir_mc #(.N(N), .M(M), .C(C), .K(K)) dut (
    .ck(ck), .rst(rst), .in(in), .in_ch(in_ch), .input_ready(input_ready),
    .busy(busy), .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out(out), .out_ch(out_ch), .output_ready(output_ready)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic longint model_out(input int c);
    longint acc = 0;
    longint r;
    longint lim = longint'(1) <<< (M - 1);
    for (int i = 0; i < N; i++) acc += m_line[c][i] * m_coef[i];
    r = (acc + (longint'(1) <<< (K - 2))) >>> (K - 1);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim)    r = -lim;
    return r;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < C; c++)
      for (int i = 0; i < N; i++) m_line[c][i] = 0;
    for (int i = 0; i < N; i++) m_coef[i] = 0;
  endfunction

  function automatic void model_accept(input longint s, input int ch, input bit clr);
    int c = ch % C;
    longint r;
    logic signed [M-1:0] d;
    if (clr)
      for (int cc = 0; cc < C; cc++)
        for (int i = 0; i < N; i++) m_line[cc][i] = 0;
    for (int i = N - 1; i > 0; i--) m_line[c][i] = m_line[c][i-1];
    m_line[c][0] = s;
    r = model_out(c);
    d = r[M-1:0];
    q_d.push_back(d);
    q_c.push_back(CW'(c));
  endfunction

  // Scoreboard consumer
  logic signed [M-1:0] sb_d;
  logic [CW-1:0]       sb_c;
  always @(negedge ck) begin
    if (!rst && output_ready) begin
      checks++;
      if (q_d.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got out=%0d ch=%0d, required no pulse", out, out_ch);
      end else begin
        sb_d = q_d.pop_front();
        sb_c = q_c.pop_front();
        if (out !== sb_d || out_ch !== sb_c) begin
          errors++;
          $display("FAIL scoreboard_data: got out=%0d ch=%0d, required out=%0d ch=%0d",
                   out, out_ch, sb_d, sb_c);
        end
      end
    end
  end

  task automatic write_coef(input int addr, input longint data, input bit applies);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = data[K-1:0];
    if (applies) m_coef[addr] = data;
    @(negedge ck);
    coef_we = 1'b0;
  endtask

  task automatic send(input longint s, input int ch, input bit clr);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge ck);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: busy=%0d, required 0", busy);
    end
    in          = s[M-1:0];
    in_ch       = CW'(ch);
    input_ready = 1'b1;
    clear       = clr;
    model_accept(s, ch, clr);
    @(negedge ck);
    input_ready = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic wait_out(output logic signed [M-1:0] o, output logic [CW-1:0] oc);
    int n = 0;
    while (!output_ready && n < 60) begin
      @(negedge ck);
      n++;
    end
    checks++;
    if (!output_ready) begin
      errors++;
      $display("FAIL wait_out_timeout: output_ready=%0d, required 1", output_ready);
    end
    o  = out;
    oc = out_ch;
    @(negedge ck);
  endtask

  task automatic test_reset();
    checks++;
    if (out !== '0 || out_ch !== '0) begin
      errors++;
      $display("FAIL reset_out: got out=%0d ch=%0d, required 0 0", out, out_ch);
    end
    checks++;
    if (output_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got output_ready=%0d busy=%0d, required 0 0", output_ready, busy);
    end
    rst = 1'b0;
    @(negedge ck);
    checks++;
    if (busy !== 1'b0 || output_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%0d output_ready=%0d, required 0 0", busy, output_ready);
    end
  endtask

  task automatic test_basic_gain();
    int n = 0;
    write_coef(0, 16384, 1'b1);
    send(1000, 0, 1'b0);
    while (!output_ready && n < 40) begin
      @(negedge ck);
      n++;
    end
    checks++;
    if (n !== 18) begin
      errors++;
      $display("FAIL gain_latency: got %0d cycles, required 18", n);
    end
    checks++;
    if (out !== 24'sd500 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL gain_value: got out=%0d ch=%0d, required 500 0", out, out_ch);
    end
    @(negedge ck);
    checks++;
    if (output_ready !== 1'b0 || out !== 24'sd500) begin
      errors++;
      $display("FAIL gain_pulse: got output_ready=%0d out=%0d, required 0 500", output_ready, out);
    end
  endtask

  task automatic test_impulse();
    logic signed [M-1:0] o;
    logic [CW-1:0] oc;
    for (int i = 0; i < N; i++) write_coef(i, 100 * (i + 1), 1'b1);
    for (int k = 0; k < N; k++) begin
      send((k == 0) ? 32768 : 0, 1, k == 0);
      wait_out(o, oc);
      checks++;
      if (o !== 100 * (k + 1) || oc !== 2'd1) begin
        errors++;
        $display("FAIL impulse_%0d: got out=%0d ch=%0d, required %0d 1", k, o, oc, 100 * (k + 1));
      end
    end
  endtask

  task automatic test_channel_isolation();
    logic signed [M-1:0] o;
    logic [CW-1:0] oc;
    longint e;
    for (int k = 0; k < N; k++) begin
      send((k == 0) ? 32768 : 0, 2, k == 0);
      wait_out(o, oc);
      checks++;
      if (o !== 100 * (k + 1) || oc !== 2'd2) begin
        errors++;
        $display("FAIL isolation_ch2_%0d: got out=%0d ch=%0d, required %0d 2", k, o, oc, 100 * (k + 1));
      end
      send(1000, 3, 1'b0);
      wait_out(o, oc);
      e = (longint'(100000) * (k + 1) * (k + 2) / 2 + 16384) >>> 15;
      checks++;
      if (o !== e || oc !== 2'd3) begin
        errors++;
        $display("FAIL isolation_ch3_%0d: got out=%0d ch=%0d, required %0d 3", k, o, oc, e);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [M-1:0] o;
    logic [CW-1:0] oc;
    write_coef(0, 32767, 1'b1);
    write_coef(1, 32767, 1'b1);
    for (int i = 2; i < N; i++) write_coef(i, 0, 1'b1);
    send(8388607, 0, 1'b1);
    wait_out(o, oc);
    send(8388607, 0, 1'b0);
    wait_out(o, oc);
    checks++;
    if (o !== 24'sd8388607) begin
      errors++;
      $display("FAIL sat_pos: got %0d, required 8388607", o);
    end
    send(-8388608, 0, 1'b0);
    wait_out(o, oc);
    send(-8388608, 0, 1'b0);
    wait_out(o, oc);
    checks++;
    if (o !== -24'sd8388608) begin
      errors++;
      $display("FAIL sat_neg: got %0d, required -8388608", o);
    end
  endtask

  task automatic test_rounding();
    logic signed [M-1:0] o;
    logic [CW-1:0] oc;
    write_coef(0, 1, 1'b1);
    write_coef(1, 0, 1'b1);
    send(16384, 0, 1'b1);
    wait_out(o, oc);
    checks++;
    if (o !== 24'sd1) begin
      errors++;
      $display("FAIL round_half_pos: got %0d, required 1", o);
    end
    send(-16384, 0, 1'b0);
    wait_out(o, oc);
    checks++;
    if (o !== 24'sd0) begin
      errors++;
      $display("FAIL round_half_neg: got %0d, required 0", o);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int last = 0;
    in          = 24'sd2000;
    in_ch       = 2'd0;
    input_ready = 1'b1;
    clear       = 1'b1;
    model_accept(2000, 0, 1'b1);
    model_accept(2000, 0, 1'b0);
    model_accept(2000, 0, 1'b0);
    for (int c = 1; c <= 70; c++) begin
      @(negedge ck);
      if (c == 1) clear = 1'b0;
      if (c == 39) input_ready = 1'b0;
      if (output_ready) begin
        pulses++;
        if (pulses > 1) begin
          checks++;
          if (c - last !== 19) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, required 19", c - last);
          end
        end
        last = c;
      end
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, required 3", pulses);
    end
  endtask

  task automatic test_coef_write_busy();
    logic signed [M-1:0] o;
    logic [CW-1:0] oc;
    send(16384, 0, 1'b1);
    repeat (2) @(negedge ck);
    write_coef(0, 32767, 1'b0);
    wait_out(o, oc);
    checks++;
    if (o !== 24'sd1) begin
      errors++;
      $display("FAIL coef_busy_now: got %0d, required 1", o);
    end
    send(16384, 0, 1'b1);
    wait_out(o, oc);
    checks++;
    if (o !== 24'sd1) begin
      errors++;
      $display("FAIL coef_busy_after: got %0d, required 1", o);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [M-1:0] o;
    logic [CW-1:0] oc;
    int pulses = 0;
    send(16384, 0, 1'b1);
    repeat (6) @(negedge ck);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || output_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flags: got busy=%0d output_ready=%0d, required 0 0", busy, output_ready);
    end
    q_d.delete();
    q_c.delete();
    model_reset();
    @(negedge ck);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge ck);
      if (output_ready) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got %0d pulses, required 0", pulses);
    end
    send(16384, 0, 1'b0);
    wait_out(o, oc);
    checks++;
    if (o !== 24'sd0) begin
      errors++;
      $display("FAIL reset_mid_coef: got %0d, required 0", o);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in          = '0;
    in_ch       = '0;
    input_ready = 1'b0;
    clear       = 1'b0;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    model_reset();
    repeat (2) @(negedge ck);
    test_reset();
    test_basic_gain();
    test_impulse();
    test_channel_isolation();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_coef_write_busy();
    test_reset_mid();
    repeat (3) @(negedge ck);
    checks++;
    if (q_d.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q_d.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
